// File: rtl/muldiv_ctl.sv
// Multi-cycle MULT/MULTU (and optionally DIV/DIVU) sequencer: stalls the front end, drives the datapath opcode, strobes HI/LO.
// Define MULDIV_CTL_DIV_EN to make DIV/DIVU multi-cycle; otherwise they pass through as single-cycle codes.
module muldiv_ctl #(
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned MUL_CYCLES = 32,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               kill,
    output logic               PCWrite,
    output logic               IF_ID_Write,
    output logic               MULrst,
    output logic [FUNCT_W-1:0] MULOut,
    output logic               HiLoWrite,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [FUNCT_W-1:0] OP_MULT  = FUNCT_W'(24);
    localparam logic [FUNCT_W-1:0] OP_MULTU = FUNCT_W'(25);
    localparam logic [FUNCT_W-1:0] OP_DIV   = FUNCT_W'(26);
    localparam logic [FUNCT_W-1:0] OP_DIVU  = FUNCT_W'(27);

    // Elaboration-time parameter sanity checks; no hardware is generated.
    if (MUL_CYCLES < 2 || MUL_CYCLES > 127) begin : g_bad_mul
        $error("muldiv_ctl: MUL_CYCLES out of range 2..127");
    end
    if (DIV_CYCLES < 2 || DIV_CYCLES > 127) begin : g_bad_div
        $error("muldiv_ctl: DIV_CYCLES out of range 2..127");
    end
    if ((MUL_CYCLES >= (2 ** CNT_W)) || (DIV_CYCLES >= (2 ** CNT_W))) begin : g_bad_cnt
        $error("muldiv_ctl: CNT_W too narrow for iteration count");
    end

    state_t             state, state_d;
    logic [FUNCT_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               is_multi;
    logic               last_iter;
    logic               stall;

    always_comb begin
        is_multi = (funct == OP_MULT) || (funct == OP_MULTU);
`ifdef MULDIV_CTL_DIV_EN
        is_multi = is_multi || (funct == OP_DIV) || (funct == OP_DIVU);
`endif
    end

    always_comb begin
`ifdef MULDIV_CTL_DIV_EN
        if ((op_q == OP_DIV) || (op_q == OP_DIVU))
            last_iter = (cnt == CNT_W'(DIV_CYCLES - 1));
        else
            last_iter = (cnt == CNT_W'(MUL_CYCLES - 1));
`else
        last_iter = (cnt == CNT_W'(MUL_CYCLES - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            op_q  <= op_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        op_d      = op_q;
        cnt_d     = cnt;
        stall     = 1'b0;
        MULrst    = 1'b0;
        MULOut    = funct;
        HiLoWrite = 1'b0;
        busy      = 1'b0;

        case (state)
            IDLE: begin
                if (start && is_multi && !kill) begin
                    stall   = 1'b1;
                    op_d    = funct;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                stall  = 1'b1;
                busy   = 1'b1;
                MULOut = op_q;
                MULrst = (cnt == '0);
                if (kill) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (last_iter) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                MULOut    = '1;
                HiLoWrite = !kill;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Reset holds the front end running and the datapath quiet regardless of state.
        if (!rst) begin
            stall     = 1'b0;
            MULrst    = 1'b0;
            MULOut    = '0;
            HiLoWrite = 1'b0;
            busy      = 1'b0;
        end

        PCWrite     = !stall;
        IF_ID_Write = !stall;
    end

endmodule

// File: tb/tb_muldiv_ctl.sv
// Self-checking bench for muldiv_ctl: directed scenarios then random traffic against a per-operation timeline model.
module tb_muldiv_ctl;

    localparam int unsigned FW     = 6;
    localparam int unsigned MUL_N  = 32;
    localparam int unsigned DIV_N  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [FW-1:0] funct = '0;
    logic          kill = 1'b0;
    logic          PCWrite, IF_ID_Write, MULrst, HiLoWrite, busy;
    logic [FW-1:0] MULOut;

    int checks = 0;
    int errors = 0;
    int hilo_cnt = 0;
    int mulrst_cnt = 0;

    // Model: m_t = cycles since the accepting edge (0 = no operation), m_n = RUN length.
    int            m_t = 0;
    int            m_n = 0;
    logic [FW-1:0] m_op = '0;

    muldiv_ctl #(
        .FUNCT_W   (FW),
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N),
        .CNT_W     (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct      (funct),
        .kill       (kill),
        .PCWrite    (PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .MULrst     (MULrst),
        .MULOut     (MULOut),
        .HiLoWrite  (HiLoWrite),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int op_len(input logic [FW-1:0] f);
        if (f == 6'd24 || f == 6'd25) return MUL_N;
`ifdef MULDIV_CTL_DIV_EN
        if (f == 6'd26 || f == 6'd27) return DIV_N;
`endif
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [FW-1:0] f, input logic k);
        logic          acc;
        logic          e_pc, e_mr, e_hl, e_busy;
        logic [FW-1:0] e_out;
        @(negedge clk);
        rst = r; start = s; funct = f; kill = k;
        #1;
        acc = 1'b0;
        if (!r) begin
            e_pc = 1; e_mr = 0; e_hl = 0; e_busy = 0; e_out = '0;
        end else if (m_t == 0) begin
            acc = s && (op_len(f) != 0) && !k;
            e_pc = !acc; e_mr = 0; e_hl = 0; e_busy = 0; e_out = f;
        end else if (m_t <= m_n) begin
            e_pc = 0; e_mr = (m_t == 1); e_hl = 0; e_busy = 1; e_out = m_op;
        end else begin
            e_pc = 1; e_mr = 0; e_hl = !k; e_busy = 1; e_out = '1;
        end
        chk("PCWrite", {7'b0, PCWrite}, {7'b0, e_pc});
        chk("IF_ID_Write", {7'b0, IF_ID_Write}, {7'b0, e_pc});
        chk("MULrst", {7'b0, MULrst}, {7'b0, e_mr});
        chk("HiLoWrite", {7'b0, HiLoWrite}, {7'b0, e_hl});
        chk("busy", {7'b0, busy}, {7'b0, e_busy});
        chk("MULOut", {2'b0, MULOut}, {2'b0, e_out});
        if (HiLoWrite === 1'b1) hilo_cnt++;
        if (MULrst === 1'b1) mulrst_cnt++;
        if (!r) m_t = 0;
        else if (m_t == 0) begin
            if (acc) begin m_t = 1; m_op = f; m_n = op_len(f); end
        end
        else if (k || m_t == m_n + 1) m_t = 0;
        else m_t++;
        @(posedge clk);
    endtask

    initial begin
        logic          r, s, k;
        logic [FW-1:0] f;

        // Reset held with a pending MULTU request
        step(0, 1, 6'd25, 0);
        step(0, 1, 6'd25, 0);

        // MULTU: accept, 32 RUN cycles, DONE
        hilo_cnt = 0; mulrst_cnt = 0;
        step(1, 1, 6'd25, 0);
        repeat (MUL_N + 1) step(1, 0, 6'd25, 0);
        step(1, 0, 6'd0, 0);
        chk("multu_hilo_pulses", 8'(hilo_cnt), 8'd1);
        chk("multu_mulrst_pulses", 8'(mulrst_cnt), 8'd1);

        // DIV: 8-cycle operation when enabled, pass-through otherwise
        hilo_cnt = 0;
        step(1, 1, 6'd26, 0);
        repeat (DIV_N + 3) step(1, 0, 6'd26, 0);
`ifdef MULDIV_CTL_DIV_EN
        chk("div_hilo_pulses", 8'(hilo_cnt), 8'd1);
`else
        chk("div_hilo_pulses", 8'(hilo_cnt), 8'd0);
`endif

        // Abort MULT at counter 5
        hilo_cnt = 0;
        step(1, 1, 6'd24, 0);
        repeat (5) step(1, 0, 6'd24, 0);
        step(1, 0, 6'd24, 1);
        repeat (3) step(1, 0, 6'd24, 0);
        chk("abort_hilo_pulses", 8'(hilo_cnt), 8'd0);

        // kill with start in IDLE
        step(1, 1, 6'd24, 1);
        step(1, 0, 6'd0, 0);

        // funct held at MULTU: one operation through DONE, next start only from IDLE
        hilo_cnt = 0;
        repeat (MUL_N + 2) step(1, 1, 6'd25, 0);
        chk("held_hilo_pulses", 8'(hilo_cnt), 8'd1);
        step(1, 1, 6'd25, 0);
        step(1, 0, 6'd25, 1);
        step(1, 0, 6'd0, 0);

        // kill in DONE suppresses HI/LO write
        hilo_cnt = 0;
        step(1, 1, 6'd24, 0);
        repeat (MUL_N) step(1, 0, 6'd24, 0);
        step(1, 0, 6'd24, 1);
        step(1, 0, 6'd0, 0);
        chk("done_kill_hilo_pulses", 8'(hilo_cnt), 8'd0);

        // Reset mid-operation
        hilo_cnt = 0;
        step(1, 1, 6'd25, 0);
        repeat (10) step(1, 0, 6'd25, 0);
        step(0, 0, 6'd25, 0);
        repeat (3) step(1, 0, 6'd0, 0);
        chk("reset_mid_hilo_pulses", 8'(hilo_cnt), 8'd0);

        // Random traffic
        repeat (3000) begin
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 9) < 3);
            k = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) f = FW'($urandom_range(22, 29));
            else f = FW'($urandom);
            step(r, s, f, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
